// File: rtl/matmul_operand_sp.sv
`default_nettype none
// ============================================================================
// Module      : matmul_operand_sp
// Description : Operand scratchpad for the matmul calc unit. It stores A/B rows
//               and C elements, streams them as beats, then waits for finish.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_operand_sp #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [BUS_WIDTH-1:0]  data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [BUS_WIDTH-1:0]  rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  stream_i,
    output logic                  start_o,
    output logic [BUS_WIDTH-1:0]  data_a_o,
    output logic [BUS_WIDTH-1:0]  data_b_o,
    output logic [BUS_WIDTH-1:0]  data_c_o,
    input  logic                  finish_mul_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  addr_err_o
);

    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
    localparam int C_DEPTH = MAX_DIM * MAX_DIM;
    localparam int IW      = 2 * $clog2(MAX_DIM);
    localparam int RW      = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
    localparam int CW      = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;

    localparam logic [4:0]  c_op_a      = 5'b00100;
    localparam logic [4:0]  c_op_b      = 5'b01000;
    localparam logic [4:0]  c_op_c      = 5'b10000;
    localparam logic [IW:0] c_row_lim   = (IW+1)'(MAX_DIM);
    localparam logic [IW:0] c_elem_lim  = (IW+1)'(C_DEPTH);
    localparam logic [CW-1:0] c_last_beat = CW'(C_DEPTH - 1);
    localparam logic [RW-1:0] c_last_row  = RW'(MAX_DIM - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    // One-hot legal target {C, B, A}; all-zero means the address is illegal.
    function automatic logic [2:0] f_decode(input logic [4:0] code, input logic [IW-1:0] idx);
        logic [IW:0] v_idx;
        v_idx    = {1'b0, idx};
        f_decode = 3'b000;
        case (code)
            c_op_a:  f_decode[0] = (v_idx < c_row_lim);
            c_op_b:  f_decode[1] = (v_idx < c_row_lim);
            c_op_c:  f_decode[2] = (v_idx < c_elem_lim);
            default: f_decode    = 3'b000;
        endcase
    endfunction

    logic [BUS_WIDTH-1:0] r_mem_a [MAX_DIM];
    logic [BUS_WIDTH-1:0] r_mem_b [MAX_DIM];
    logic [BUS_WIDTH-1:0] r_mem_c [C_DEPTH];

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_beat;
    logic [CW-1:0]        w_beat_nxt;
    logic [RW-1:0]        r_row;
    logic [RW-1:0]        w_row_nxt;
    logic                 w_load;
    logic                 w_done_nxt;

    logic [2:0]           w_wr_hit;
    logic [2:0]           w_rd_hit;
    logic [RW-1:0]        w_wr_row;
    logic [CW-1:0]        w_wr_elem;
    logic [RW-1:0]        w_rd_row;
    logic [CW-1:0]        w_rd_elem;
    logic [BUS_WIDTH-1:0] w_rd_word;
    logic                 w_wr_err;
    logic                 w_rd_err;

    logic [BUS_WIDTH-1:0] r_rd_data;
    logic                 r_rd_valid;
    logic                 r_start;
    logic                 r_done;
    logic                 r_addr_err;
    logic [BUS_WIDTH-1:0] r_data_a;
    logic [BUS_WIDTH-1:0] r_data_b;
    logic [BUS_WIDTH-1:0] r_data_c;

    // Address bits above the index field carry no meaning here.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{addr_i[ADDR_WIDTH-1:5+IW], rd_addr_i[ADDR_WIDTH-1:5+IW]};

    assign w_wr_hit  = f_decode(addr_i[4:0], addr_i[5 +: IW]);
    assign w_rd_hit  = f_decode(rd_addr_i[4:0], rd_addr_i[5 +: IW]);
    assign w_wr_row  = addr_i[5 +: RW];
    assign w_wr_elem = addr_i[5 +: CW];
    assign w_rd_row  = rd_addr_i[5 +: RW];
    assign w_rd_elem = rd_addr_i[5 +: CW];
    assign w_wr_err  = we_i && (w_wr_hit == 3'b000);
    assign w_rd_err  = rd_en_i && (w_rd_hit == 3'b000);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MAX_DIM; i++) begin
                r_mem_a[i] <= '0;
                r_mem_b[i] <= '0;
            end
            for (int i = 0; i < C_DEPTH; i++) begin
                r_mem_c[i] <= '0;
            end
        end else if (we_i) begin
            if (w_wr_hit[0]) r_mem_a[w_wr_row]  <= data_i;
            if (w_wr_hit[1]) r_mem_b[w_wr_row]  <= data_i;
            if (w_wr_hit[2]) r_mem_c[w_wr_elem] <= data_i;
        end
    end

    always_comb begin
        w_rd_word = '0;
        if (w_rd_hit[0])      w_rd_word = r_mem_a[w_rd_row];
        else if (w_rd_hit[1]) w_rd_word = r_mem_b[w_rd_row];
        else if (w_rd_hit[2]) w_rd_word = r_mem_c[w_rd_elem];
    end

    // Reads sample storage before this edge's write lands: read-before-write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_rd_data  <= rd_en_i ? w_rd_word : '0;
            r_rd_valid <= rd_en_i;
            r_addr_err <= r_addr_err | w_wr_err | w_rd_err;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_row   <= w_row_nxt;
        end
    end

    // r_beat/r_row name the beat currently on the outputs; w_load fetches the next one.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_row_nxt   = r_row;
        w_load      = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (stream_i) begin
                    w_state_nxt = ST_STREAM;
                    w_beat_nxt  = '0;
                    w_row_nxt   = '0;
                    w_load      = 1'b1;
                end
            end
            ST_STREAM: begin
                if (r_beat == c_last_beat) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_beat_nxt = r_beat + CW'(1);
                    w_row_nxt  = (r_row == c_last_row) ? '0 : r_row + RW'(1);
                    w_load     = 1'b1;
                end
            end
            ST_WAIT: begin
                if (finish_mul_i) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_start  <= 1'b0;
            r_done   <= 1'b0;
            r_data_a <= '0;
            r_data_b <= '0;
            r_data_c <= '0;
        end else begin
            r_start  <= w_load;
            r_done   <= w_done_nxt;
            r_data_a <= w_load ? r_mem_a[w_row_nxt]  : '0;
            r_data_b <= w_load ? r_mem_b[w_row_nxt]  : '0;
            r_data_c <= w_load ? r_mem_c[w_beat_nxt] : '0;
        end
    end

    assign rd_data_o  = r_rd_data;
    assign rd_valid_o = r_rd_valid;
    assign start_o    = r_start;
    assign data_a_o   = r_data_a;
    assign data_b_o   = r_data_b;
    assign data_c_o   = r_data_c;
    assign busy_o     = (r_state != ST_IDLE);
    assign done_o     = r_done;
    assign addr_err_o = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_matmul_operand_sp.sv
`default_nettype none
// Bench for matmul_operand_sp: cycle-level behavioural model plus directed
// vectors with literal expectations.
module tb_matmul_operand_sp;

    localparam logic [4:0] OP_A = 5'b00100;
    localparam logic [4:0] OP_B = 5'b01000;
    localparam logic [4:0] OP_C = 5'b10000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [15:0] data_i = '0;
    logic        rd_en_i = 1'b0;
    logic [31:0] rd_addr_i = '0;
    logic        stream_i = 1'b0;
    logic        finish_mul_i = 1'b0;
    logic [15:0] rd_data_o, data_a_o, data_b_o, data_c_o;
    logic        rd_valid_o, start_o, busy_o, done_o, addr_err_o;

    int checks = 0;
    int errors = 0;

    matmul_operand_sp #(.DATA_WIDTH(8), .BUS_WIDTH(16), .ADDR_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
        .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .stream_i(stream_i), .start_o(start_o), .data_a_o(data_a_o), .data_b_o(data_b_o),
        .data_c_o(data_c_o), .finish_mul_i(finish_mul_i), .busy_o(busy_o), .done_o(done_o),
        .addr_err_o(addr_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] ma [2];
    logic [15:0] mb [2];
    logic [15:0] mc [4];
    int          mode;
    int          beat;
    logic        e_start, e_done, e_busy, e_rdv, e_err;
    logic [15:0] e_a, e_b, e_c, e_rd;

    function automatic bit m_legal(input logic [31:0] a);
        logic [1:0] idx;
        idx = a[6:5];
        case (a[4:0])
            OP_A, OP_B: return (idx < 2'd2);
            OP_C:       return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] m_fetch(input logic [31:0] a);
        int idx;
        idx = int'(a[6:5]);
        case (a[4:0])
            OP_A:    return ma[idx];
            OP_B:    return mb[idx];
            default: return mc[idx];
        endcase
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 2; i++) begin ma[i] = '0; mb[i] = '0; end
        for (int i = 0; i < 4; i++) mc[i] = '0;
        mode = 0; beat = 0;
        e_start = 0; e_done = 0; e_busy = 0; e_rdv = 0; e_err = 0;
        e_a = '0; e_b = '0; e_c = '0; e_rd = '0;
    endtask

    task automatic m_step();
        int idx;
        e_rdv = rd_en_i;
        e_rd  = '0;
        if (rd_en_i) begin
            if (m_legal(rd_addr_i)) e_rd = m_fetch(rd_addr_i);
            else e_err = 1'b1;
        end
        e_done = 1'b0;
        if (mode == 0) begin
            if (stream_i) begin mode = 1; beat = 0; end
        end else if (mode == 1) begin
            beat++;
            if (beat == 4) mode = 2;
        end else if (finish_mul_i) begin
            mode = 0; e_done = 1'b1;
        end
        e_start = (mode == 1);
        e_busy  = (mode != 0);
        if (mode == 1) begin
            e_a = ma[beat % 2]; e_b = mb[beat % 2]; e_c = mc[beat];
        end else begin
            e_a = '0; e_b = '0; e_c = '0;
        end
        if (we_i) begin
            if (m_legal(addr_i)) begin
                idx = int'(addr_i[6:5]);
                case (addr_i[4:0])
                    OP_A:    ma[idx] = data_i;
                    OP_B:    mb[idx] = data_i;
                    default: mc[idx] = data_i;
                endcase
            end else begin
                e_err = 1'b1;
            end
        end
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) m_clear();
            else m_step();
        end
    end

    // Compare every cycle once the first reset has been released.
    initial begin
        wait (rst_ni === 1'b1);
        forever begin
            @(negedge clk_i);
            cmp("mdl_start", 16'(start_o), 16'(e_start));
            cmp("mdl_busy", 16'(busy_o), 16'(e_busy));
            cmp("mdl_done", 16'(done_o), 16'(e_done));
            cmp("mdl_a", data_a_o, e_a);
            cmp("mdl_b", data_b_o, e_b);
            cmp("mdl_c", data_c_o, e_c);
            cmp("mdl_rdv", 16'(rd_valid_o), 16'(e_rdv));
            cmp("mdl_err", 16'(addr_err_o), 16'(e_err));
            if (e_rdv) cmp("mdl_rd", rd_data_o, e_rd);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [4:0] code, input logic [1:0] idx, input logic [15:0] d);
        logic [31:0] a;
        a      = $urandom();
        a[6:0] = {idx, code};
        we_i = 1'b1; addr_i = a; data_i = d;
        tick();
        we_i = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [4:0] code, input logic [1:0] idx,
                      input logic [15:0] exp);
        rd_addr_i = {25'h0, idx, code}; rd_en_i = 1'b1;
        tick();
        rd_en_i = 1'b0;
        cmp({nm, "_valid"}, 16'(rd_valid_o), 16'h1);
        cmp(nm, rd_data_o, exp);
    endtask

    logic [15:0] exp_a [4] = '{16'h0201, 16'h0403, 16'h0201, 16'h0403};
    logic [15:0] exp_b [4] = '{16'h0605, 16'h0807, 16'h0605, 16'h0807};
    logic [15:0] exp_c [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};

    initial begin
        int n_start;
        int n_done;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        cmp("rst_busy", 16'(busy_o), 16'h0);
        cmp("rst_start", 16'(start_o), 16'h0);
        cmp("rst_err", 16'(addr_err_o), 16'h0);
        cmp("rst_rdv", 16'(rd_valid_o), 16'h0);

        wr(OP_A, 2'd0, 16'h0201); wr(OP_A, 2'd1, 16'h0403);
        wr(OP_B, 2'd0, 16'h0605); wr(OP_B, 2'd1, 16'h0807);
        for (int i = 0; i < 4; i++) wr(OP_C, 2'(i), 16'(i + 1));

        stream_i = 1'b1; tick(); stream_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            cmp("beat_start", 16'(start_o), 16'h1);
            cmp("beat_a", data_a_o, exp_a[b]);
            cmp("beat_b", data_b_o, exp_b[b]);
            cmp("beat_c", data_c_o, exp_c[b]);
            tick();
        end
        cmp("wait_start", 16'(start_o), 16'h0);
        cmp("wait_busy", 16'(busy_o), 16'h1);

        wr(OP_C, 2'd2, 16'h00AA);
        finish_mul_i = 1'b1; tick(); finish_mul_i = 1'b0;
        cmp("done_pulse", 16'(done_o), 16'h1);
        cmp("done_busy", 16'(busy_o), 16'h0);
        tick();
        cmp("done_clear", 16'(done_o), 16'h0);
        rd("rd_c2", OP_C, 2'd2, 16'h00AA);

        wr(5'b00001, 2'd0, 16'hDEAD);
        cmp("err_code", 16'(addr_err_o), 16'h1);
        wr(OP_A, 2'd3, 16'hBEEF);
        rd("rd_a0", OP_A, 2'd0, 16'h0201);
        rd("rd_a1", OP_A, 2'd1, 16'h0403);
        rd("rd_bad", 5'b00010, 2'd0, 16'h0000);

        we_i = 1'b1; addr_i = {25'h0, 2'd1, OP_B}; data_i = 16'h1111;
        rd_en_i = 1'b1; rd_addr_i = {25'h0, 2'd1, OP_B};
        tick();
        we_i = 1'b0; rd_en_i = 1'b0;
        cmp("rbw_old", rd_data_o, 16'h0807);
        rd("rbw_new", OP_B, 2'd1, 16'h1111);

        stream_i = 1'b1; tick();
        n_start = 0; n_done = 0;
        for (int k = 0; k < 8; k++) begin
            if (start_o) n_start++;
            if (done_o) n_done++;
            stream_i     = (k < 2);
            finish_mul_i = (k < 3);
            tick();
        end
        stream_i = 1'b0; finish_mul_i = 1'b0;
        cmp("ign_beats", 16'(n_start), 16'd4);
        cmp("ign_done", 16'(n_done), 16'd0);
        cmp("ign_busy", 16'(busy_o), 16'h1);
        finish_mul_i = 1'b1; tick(); finish_mul_i = 1'b0;
        cmp("ign_fin", 16'(done_o), 16'h1);
        cmp("err_sticky", 16'(addr_err_o), 16'h1);

        stream_i = 1'b1; tick(); stream_i = 1'b0;
        tick(); tick();
        rst_ni = 1'b0;
        #1;
        cmp("mrst_start", 16'(start_o), 16'h0);
        cmp("mrst_busy", 16'(busy_o), 16'h0);
        cmp("mrst_a", data_a_o, 16'h0);
        cmp("mrst_err", 16'(addr_err_o), 16'h0);
        tick(); tick();
        rst_ni = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            rd("z_a", OP_A, 2'(i), 16'h0);
            rd("z_b", OP_B, 2'(i), 16'h0);
        end
        for (int i = 0; i < 4; i++) rd("z_c", OP_C, 2'(i), 16'h0);
        cmp("z_err", 16'(addr_err_o), 16'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
